// File: rtl/ahb_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_pkg
// Description : Shared encodings, response-state type and byte-lane mask
//               helper for the AHB-Lite to SRAM bridge.
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_sram_pkg;

    // HTRANS encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // HSIZE encodings supported by this responder
    localparam logic [2:0] c_HSIZE_BYTE = 3'd0;
    localparam logic [2:0] c_HSIZE_HALF = 3'd1;
    localparam logic [2:0] c_HSIZE_WORD = 3'd2;

    // Two-cycle ERROR response sequence
    typedef enum logic [1:0] {
        OKAY = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } resp_state_t;

    // Active byte lanes of a transfer. Misaligned halfword/word cases are
    // rejected as errors before the mask is ever used.
    function automatic logic [3:0] byte_mask(input logic [2:0] hsize,
                                             input logic [1:0] addr);
        case (hsize)
            c_HSIZE_BYTE: byte_mask = 4'b0001 << addr;
            c_HSIZE_HALF: byte_mask = 4'b0011 << addr;
            default:      byte_mask = 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_wbuf.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_wbuf
// Description : One-entry posted write buffer. Holds the last write, drains
//               it to the SRAM whenever no read owns the SRAM port, and merges
//               buffered bytes into read data on a word-address match.
// Revision    : 1.0 - initial release
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_load_*          - write data phase completing: new contents
//               i_rd_ap           - read address phase using the SRAM this cycle
//               i_rd_addr         - word address of the current read data phase
//               i_sram_rdata      - raw SRAM read data
//               o_drain_*         - SRAM write request from the buffer
//               o_valid           - buffer holds an undrained write
//               o_rdata           - read data with buffered bytes forwarded
// ============================================================================
module ahb_sram_wbuf #(
    parameter int AW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [AW-1:0] i_load_addr,
    input  logic [31:0]   i_load_data,
    input  logic [3:0]    i_load_mask,
    input  logic          i_rd_ap,
    input  logic [AW-1:0] i_rd_addr,
    input  logic [31:0]   i_sram_rdata,
    output logic          o_drain,
    output logic [AW-1:0] o_drain_addr,
    output logic [31:0]   o_drain_data,
    output logic [3:0]    o_drain_mask,
    output logic          o_valid,
    output logic [31:0]   o_rdata
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_data;
    logic [3:0]    r_mask;
    logic          w_hit;

    // A read address phase owns the SRAM port; otherwise drain.
    assign o_drain      = r_valid & ~i_rd_ap;
    assign o_drain_addr = r_addr;
    assign o_drain_data = r_data;
    assign o_drain_mask = r_mask;
    assign o_valid      = r_valid;

    // A load in the same cycle as a drain wins: the drain has already used
    // the old contents on the SRAM port this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_load_addr;
            r_data  <= i_load_data;
            r_mask  <= i_load_mask;
        end else if (o_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign w_hit = r_valid & (r_addr == i_rd_addr);

    for (genvar i = 0; i < 4; i++) begin : g_lane
        assign o_rdata[8*i +: 8] = (w_hit & r_mask[i]) ? r_data[8*i +: 8]
                                                       : i_sram_rdata[8*i +: 8];
    end

endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : ahb_sram_slave
// Description : AHB-Lite responder in front of a single-port synchronous SRAM
//               with byte write enables. Zero-wait reads and posted writes
//               through a one-entry buffer; two-cycle ERROR response.
// Revision    : 1.0 - initial release
// Ports       : HCLK, HRESET      - clock, synchronous active-high reset
//               HSEL..HREADY      - AHB-Lite address/data phase inputs
//               HREADYOUT, HRESP  - slave ready and response
//               HRDATA            - read data
//               SRAMRDATA         - SRAM read data (1 cycle after strobe)
//               SRAMADDR/WDATA/WEN/CS - SRAM control
// ============================================================================
module ahb_sram_slave
    import ahb_sram_pkg::*;
#(
    parameter int AW = 15
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [AW-1:0] SRAMADDR,
    output logic [31:0]   SRAMWDATA,
    output logic [3:0]    SRAMWEN,
    output logic          SRAMCS
);

    resp_state_t   r_state;
    resp_state_t   w_state_nxt;
    logic          r_rd_dp;
    logic          r_wr_dp;
    logic [AW-1:0] r_dp_addr;
    logic [3:0]    r_dp_mask;

    logic          w_accept;
    logic          w_size_ok;
    logic          w_err;
    logic          w_rd_ap;
    logic          w_wr_ap;
    logic          w_stall;
    logic          w_load;
    logic          w_drain;
    logic          w_buf_valid;
    logic [AW-1:0] w_drain_addr;
    logic [31:0]   w_drain_data;
    logic [3:0]    w_drain_mask;
    logic [31:0]   w_fwd_rdata;
    logic          w_unused;

    // Upper address bits alias; HTRANS[0] does not affect acceptance.
    assign w_unused = &{1'b0, HADDR[31:AW+2], HTRANS[0]};

    assign w_accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        w_size_ok = 1'b0;
        case (HSIZE)
            c_HSIZE_BYTE: w_size_ok = 1'b1;
            c_HSIZE_HALF: w_size_ok = ~HADDR[0];
            c_HSIZE_WORD: w_size_ok = (HADDR[1:0] == 2'b00);
            default:      w_size_ok = 1'b0;
        endcase
    end

    assign w_err   = w_accept & ~w_size_ok;
    assign w_rd_ap = w_accept &  w_size_ok & ~HWRITE;
    assign w_wr_ap = w_accept &  w_size_ok &  HWRITE;

    // Write data phase immediately after another write: the buffer is still
    // full (loaded at the end of the previous cycle). If a read is knocking,
    // it would block the drain and the load would overwrite undrained data,
    // so hold the bus one cycle; the drain runs and the load follows.
    // Deliberately independent of HREADY to avoid a combinational loop.
    assign w_stall = r_wr_dp & w_buf_valid & HSEL & HTRANS[1] & ~HWRITE & w_size_ok;

    assign w_load  = r_wr_dp & HREADY;

    // Data-phase tracking advances only when the bus advances
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_rd_dp   <= 1'b0;
            r_wr_dp   <= 1'b0;
            r_dp_addr <= '0;
            r_dp_mask <= '0;
        end else if (HREADY) begin
            r_rd_dp <= w_rd_ap;
            r_wr_dp <= w_wr_ap;
            if (w_rd_ap | w_wr_ap) begin
                r_dp_addr <= HADDR[AW+1:2];
                r_dp_mask <= byte_mask(HSIZE, HADDR[1:0]);
            end
        end
    end

    // Response FSM: state register
    always_ff @(posedge HCLK) begin
        if (HRESET) r_state <= OKAY;
        else        r_state <= w_state_nxt;
    end

    // Response FSM: next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        HREADYOUT   = 1'b1;
        HRESP       = 1'b0;
        case (r_state)
            OKAY: begin
                HREADYOUT = ~w_stall;
                if (w_err) w_state_nxt = ERR1;
            end
            ERR1: begin
                HREADYOUT   = 1'b0;
                HRESP       = 1'b1;
                w_state_nxt = ERR2;
            end
            ERR2: begin
                HRESP       = 1'b1;
                w_state_nxt = w_err ? ERR1 : OKAY;
            end
            default: w_state_nxt = OKAY;
        endcase
        if (HRESET) begin
            HREADYOUT = 1'b1;
            HRESP     = 1'b0;
        end
    end

    ahb_sram_wbuf #(
        .AW (AW)
    ) u_wbuf (
        .clk          (HCLK),
        .rst          (HRESET),
        .i_load       (w_load),
        .i_load_addr  (r_dp_addr),
        .i_load_data  (HWDATA),
        .i_load_mask  (r_dp_mask),
        .i_rd_ap      (w_rd_ap),
        .i_rd_addr    (r_dp_addr),
        .i_sram_rdata (SRAMRDATA),
        .o_drain      (w_drain),
        .o_drain_addr (w_drain_addr),
        .o_drain_data (w_drain_data),
        .o_drain_mask (w_drain_mask),
        .o_valid      (w_buf_valid),
        .o_rdata      (w_fwd_rdata)
    );

    // SRAM port: a read strobe always takes priority over a drain
    always_comb begin
        SRAMCS    = 1'b0;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = '0;
        SRAMWDATA = '0;
        if (!HRESET) begin
            if (w_rd_ap) begin
                SRAMCS   = 1'b1;
                SRAMADDR = HADDR[AW+1:2];
            end else if (w_drain) begin
                SRAMCS    = 1'b1;
                SRAMADDR  = w_drain_addr;
                SRAMWDATA = w_drain_data;
                SRAMWEN   = w_drain_mask;
            end
        end
    end

    assign HRDATA = (!HRESET && r_rd_dp) ? w_fwd_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_sram_slave
// Description : Directed self-checking bench for ahb_sram_slave with a
//               behavioural byte-writable synchronous SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;

    localparam int AW = 15;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [31:0]   SRAMRDATA = '0;
    logic [AW-1:0] SRAMADDR;
    logic [31:0]   SRAMWDATA;
    logic [3:0]    SRAMWEN;
    logic          SRAMCS;

    logic [31:0]   mem [0:(1<<AW)-1];

    int n_chk  = 0;
    int n_fail = 0;

    // Single-slave bus: HREADY follows this slave
    assign HREADY = HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.AW(AW)) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .SRAMRDATA (SRAMRDATA),
        .SRAMADDR  (SRAMADDR),
        .SRAMWDATA (SRAMWDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMCS    (SRAMCS)
    );

    // Synchronous SRAM model with byte enables
    always @(posedge HCLK) begin
        if (SRAMCS) begin
            if (SRAMWEN == 4'b0000) begin
                SRAMRDATA <= mem[SRAMADDR];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic smp();
        @(negedge HCLK);
    endtask

    task automatic drv(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        HSEL   = sel;
        HTRANS = tr;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = addr;
        HWDATA = wd;
    endtask

    task automatic idle(input logic [31:0] wd);
        drv(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, wd);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
        mem[9]    = 32'h0909_0909;
        mem[12]   = 32'hCAFE_F00D;
        mem[16]   = 32'h4040_4040;

        // Reset with a read presented: all outputs must stay quiet
        HRESET = 1'b1;
        drv(1'b1, 2'b10, 1'b0, 3'd2, 32'h40, 32'h0);
        tick(); smp();
        chk("rst_hreadyout", HREADYOUT, 1);
        chk("rst_hresp",     HRESP,     0);
        chk("rst_hrdata",    HRDATA,    0);
        chk("rst_sramcs",    SRAMCS,    0);
        chk("rst_sramwen",   SRAMWEN,   0);
        chk("rst_sramaddr",  SRAMADDR,  0);
        chk("rst_sramwdata", SRAMWDATA, 0);
        tick(); HRESET = 1'b0; idle(0); smp();
        chk("post_rst_cs", SRAMCS, 0);

        // Word write then forwarded read
        tick(); drv(1, 2'b10, 1, 3'd2, 32'h10, 0); smp();
        chk("t1_ap_ready", HREADYOUT, 1);
        chk("t1_ap_wen",   SRAMWEN,   0);
        tick(); drv(1, 2'b10, 0, 3'd2, 32'h10, 32'hDEAD_BEEF); smp();
        chk("t1_rd_cs",    SRAMCS,   1);
        chk("t1_rd_addr",  SRAMADDR, 4);
        chk("t1_rd_wen",   SRAMWEN,  0);
        tick(); idle(0); smp();
        chk("t1_fwd",        HRDATA,    32'hDEAD_BEEF);
        chk("t1_fwd_ready",  HREADYOUT, 1);
        chk("t1_drain_wen",  SRAMWEN,   4'hF);
        chk("t1_drain_addr", SRAMADDR,  4);
        chk("t1_drain_data", SRAMWDATA, 32'hDEAD_BEEF);
        tick(); idle(0); smp();
        chk("t1_idle_cs",     SRAMCS, 0);
        chk("t1_idle_hrdata", HRDATA, 0);
        chk("t1_mem",         mem[4], 32'hDEAD_BEEF);

        // Byte-lane merge
        mem[4] = 32'h1122_3344;
        tick(); drv(1, 2'b10, 1, 3'd0, 32'h12, 0); smp();
        tick(); drv(1, 2'b10, 0, 3'd2, 32'h10, 32'h00AA_0000); smp();
        tick(); idle(0); smp();
        chk("t2_merge",  HRDATA,    32'h11AA_3344);
        chk("t2_wen",    SRAMWEN,   4'b0100);
        chk("t2_wdata",  SRAMWDATA, 32'h00AA_0000);
        tick(); idle(0); smp();
        chk("t2_mem", mem[4], 32'h11AA_3344);

        // Back-to-back writes drain in consecutive cycles
        tick(); drv(1, 2'b10, 1, 3'd2, 32'h0, 0); smp();
        chk("t3_rdy0", HREADYOUT, 1);
        tick(); drv(1, 2'b11, 1, 3'd2, 32'h4, 32'hA0A0_A0A0); smp();
        chk("t3_rdy1", HREADYOUT, 1);
        chk("t3_wen1", SRAMWEN,   0);
        tick(); drv(1, 2'b11, 1, 3'd2, 32'h8, 32'hA1A1_A1A1); smp();
        chk("t3_rdy2",  HREADYOUT, 1);
        chk("t3_addr2", SRAMADDR,  0);
        chk("t3_wen2",  SRAMWEN,   4'hF);
        chk("t3_data2", SRAMWDATA, 32'hA0A0_A0A0);
        tick(); idle(32'hA2A2_A2A2); smp();
        chk("t3_rdy3",  HREADYOUT, 1);
        chk("t3_addr3", SRAMADDR,  1);
        chk("t3_data3", SRAMWDATA, 32'hA1A1_A1A1);
        tick(); idle(0); smp();
        chk("t3_addr4", SRAMADDR,  2);
        chk("t3_wen4",  SRAMWEN,   4'hF);
        chk("t3_data4", SRAMWDATA, 32'hA2A2_A2A2);
        tick(); idle(0); smp();
        chk("t3_done_cs", SRAMCS, 0);

        // Reads hold off the drain
        tick(); drv(1, 2'b10, 1, 3'd2, 32'h20, 0); smp();
        tick(); drv(1, 2'b10, 0, 3'd2, 32'h20, 32'h5566_7788); smp();
        chk("t4_wen_r0", SRAMWEN, 0);
        tick(); drv(1, 2'b11, 0, 3'd2, 32'h24, 0); smp();
        chk("t4_fwd",    HRDATA,   32'h5566_7788);
        chk("t4_wen_r1", SRAMWEN,  0);
        chk("t4_addr_r1", SRAMADDR, 9);
        tick(); drv(1, 2'b11, 0, 3'd2, 32'h28, 0); smp();
        chk("t4_nofwd",  HRDATA,  32'h0909_0909);
        chk("t4_wen_r2", SRAMWEN, 0);
        tick(); drv(1, 2'b11, 0, 3'd2, 32'h2C, 0); smp();
        chk("t4_wen_r3", SRAMWEN, 0);
        tick(); idle(0); smp();
        chk("t4_drain_wen",  SRAMWEN,   4'hF);
        chk("t4_drain_addr", SRAMADDR,  8);
        chk("t4_drain_data", SRAMWDATA, 32'h5566_7788);

        // Misaligned word read
        tick(); drv(1, 2'b10, 0, 3'd2, 32'h2, 0); smp();
        chk("t5a_ap_cs",    SRAMCS,    0);
        chk("t5a_ap_ready", HREADYOUT, 1);
        tick(); idle(0); smp();
        chk("t5a_e1_ready", HREADYOUT, 0);
        chk("t5a_e1_resp",  HRESP,     1);
        chk("t5a_e1_cs",    SRAMCS,    0);
        tick(); smp();
        chk("t5a_e2_ready", HREADYOUT, 1);
        chk("t5a_e2_resp",  HRESP,     1);
        // HSIZE=3 write
        tick(); drv(1, 2'b10, 1, 3'd3, 32'h40, 0); smp();
        chk("t5b_ap_resp", HRESP,  0);
        chk("t5b_ap_cs",   SRAMCS, 0);
        tick(); idle(32'hFFFF_FFFF); smp();
        chk("t5b_e1_ready", HREADYOUT, 0);
        chk("t5b_e1_resp",  HRESP,     1);
        chk("t5b_e1_wen",   SRAMWEN,   0);
        // Misaligned halfword accepted in ERR2 restarts the error sequence
        tick(); drv(1, 2'b10, 1, 3'd1, 32'h41, 0); smp();
        chk("t5c_e2_ready", HREADYOUT, 1);
        chk("t5c_e2_resp",  HRESP,     1);
        chk("t5c_e2_cs",    SRAMCS,    0);
        tick(); idle(32'hEEEE_EEEE); smp();
        chk("t5c_e1_ready", HREADYOUT, 0);
        chk("t5c_e1_resp",  HRESP,     1);
        chk("t5c_e1_wen",   SRAMWEN,   0);
        tick(); idle(0); smp();
        chk("t5c_e2b_ready", HREADYOUT, 1);
        tick(); drv(1, 2'b10, 0, 3'd2, 32'h40, 0); smp();
        chk("t5_okay_resp", HRESP,  0);
        chk("t5_okay_cs",   SRAMCS, 1);
        tick(); idle(0); smp();
        chk("t5_buf_clean", HRDATA,  32'h4040_4040);
        chk("t5_no_drain",  SRAMWEN, 0);

        // Reset right after a write data phase discards the buffer
        tick(); drv(1, 2'b10, 1, 3'd2, 32'h30, 0); smp();
        tick(); idle(32'h1234_5678); smp();
        tick(); HRESET = 1'b1; idle(0); smp();
        chk("t6_rst_wen",   SRAMWEN,   0);
        chk("t6_rst_cs",    SRAMCS,    0);
        chk("t6_rst_ready", HREADYOUT, 1);
        tick(); HRESET = 1'b0; drv(1, 2'b10, 0, 3'd2, 32'h30, 0); smp();
        chk("t6_rd_wen", SRAMWEN, 0);
        tick(); idle(0); smp();
        chk("t6_old_data", HRDATA,  32'hCAFE_F00D);
        chk("t6_no_wen",   SRAMWEN, 0);
        chk("t6_mem",      mem[12], 32'hCAFE_F00D);

        // Address bits above AW+1 alias
        tick(); drv(1, 2'b10, 0, 3'd2, 32'hFFFE_0010, 0); smp();
        chk("t7_wrap_addr", SRAMADDR, 4);
        tick(); idle(0); smp();
        chk("t7_wrap_data", HRDATA, 32'h11AA_3344);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
